// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle controller: FSM states, opcodes,
// R-type funct codes, ALU_OP codes and PC source selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PCS_SEQ    = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: is_legal_op = 1'b1;
      default:                       is_legal_op = 1'b0;
    endcase
  endfunction

  // Logical immediates are zero-extended; arithmetic/address/branch ones sign-extended.
  function automatic logic uses_sign_ext(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_LW, OP_SW, OP_BEQ: uses_sign_ext = 1'b1;
      default:                       uses_sign_ext = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_multiciclo_alu_op_decode.sv
// Combinational ALU function select from opcode, with the R-type funct
// field mapped onto ALU_OP codes.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op
);

  // Opcode-level select, falling through to funct for R-type
  always_comb begin
    alu_op = ALU_AND;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
      OP_BEQ:                alu_op = ALU_SUB;
      OP_ANDI:               alu_op = ALU_AND;
      OP_ORI:                alu_op = ALU_OR;
      default:               alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB FSM with
// memory handshake and a retired-instruction counter.
module control_multiciclo
  import ctrl_pkg::*;
(
  input  logic        reloj,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PC_WR,
  output logic        IR_WR,
  output logic        REG_RD,
  output logic        REG_WR,
  output logic        SEL_I,
  output logic        SEL_DST,
  output logic        SEL_WB,
  output logic [3:0]  ALU_OP,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [1:0]  PC_SRC,
  output logic        illegal,
  output logic [15:0] retired
);

  state_t      state_r;
  state_t      state_nx_s;
  logic [5:0]  op_r;
  logic [5:0]  funct_r;
  logic [15:0] retired_r;
  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [3:0]  alu_op_s;
  logic        retire_s;

  // IR is only guaranteed valid in DECODE; later states use the latched copy.
  assign op_s    = (state_r == ST_DECODE) ? opcode : op_r;
  assign funct_s = (state_r == ST_DECODE) ? funct  : funct_r;
  assign retired = retired_r;

  alu_op_decode u_alu_op_decode (
    .opcode (op_s),
    .funct  (funct_s),
    .alu_op (alu_op_s)
  );

  // State register
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Capture opcode/funct while the IR is known good
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      op_r    <= 6'd0;
      funct_r <= 6'd0;
    end else if (state_r == ST_DECODE) begin
      op_r    <= opcode;
      funct_r <= funct;
    end
  end

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      retired_r <= 16'd0;
    end else if (retire_s) begin
      retired_r <= retired_r + 16'd1;
    end
  end

  // Next state and control outputs; reset forces idle outputs asynchronously
  always_comb begin
    state_nx_s = state_r;
    PC_WR      = 1'b0;
    IR_WR      = 1'b0;
    REG_RD     = 1'b1;
    REG_WR     = 1'b1;
    SEL_I      = 1'b0;
    SEL_DST    = 1'b0;
    SEL_WB     = 1'b0;
    ALU_OP     = ALU_AND;
    MEM_RD     = 1'b0;
    MEM_WR     = 1'b0;
    PC_SRC     = PCS_SEQ;
    illegal    = 1'b0;
    retire_s   = 1'b0;
    if (!reset_n) begin
      state_nx_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          MEM_RD = 1'b1;
          if (mem_ready) begin
            IR_WR      = 1'b1;
            PC_WR      = 1'b1;
            state_nx_s = ST_DECODE;
          end else begin
            state_nx_s = ST_FETCH;
          end
        end
        ST_DECODE: begin
          REG_RD = 1'b0;
          SEL_I  = uses_sign_ext(op_s);
          ALU_OP = alu_op_s;
          if (!is_legal_op(op_s)) begin
            illegal    = 1'b1;
            state_nx_s = ST_FETCH;
          end else if (op_s == OP_J) begin
            PC_WR      = 1'b1;
            PC_SRC     = PCS_JUMP;
            retire_s   = 1'b1;
            state_nx_s = ST_FETCH;
          end else begin
            state_nx_s = ST_EXEC;
          end
        end
        ST_EXEC: begin
          SEL_I   = uses_sign_ext(op_s);
          SEL_DST = (op_s == OP_RTYPE);
          SEL_WB  = (op_s == OP_LW);
          ALU_OP  = alu_op_s;
          case (op_s)
            OP_BEQ: begin
              PC_WR      = zero;
              PC_SRC     = PCS_BRANCH;
              retire_s   = 1'b1;
              state_nx_s = ST_FETCH;
            end
            OP_LW, OP_SW: state_nx_s = ST_MEM;
            default:      state_nx_s = ST_WB;
          endcase
        end
        ST_MEM: begin
          SEL_I  = uses_sign_ext(op_s);
          SEL_WB = (op_s == OP_LW);
          ALU_OP = alu_op_s;
          if (op_s == OP_LW) begin
            MEM_RD = 1'b1;
          end else begin
            MEM_WR = 1'b1;
          end
          if (!mem_ready) begin
            state_nx_s = ST_MEM;
          end else if (op_s == OP_SW) begin
            retire_s   = 1'b1;
            state_nx_s = ST_FETCH;
          end else begin
            state_nx_s = ST_WB;
          end
        end
        ST_WB: begin
          REG_WR     = 1'b0;
          SEL_I      = uses_sign_ext(op_s);
          SEL_DST    = (op_s == OP_RTYPE);
          SEL_WB     = (op_s == OP_LW);
          ALU_OP     = alu_op_s;
          retire_s   = 1'b1;
          state_nx_s = ST_FETCH;
        end
        default: state_nx_s = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed self-checking bench for control_multiciclo: one task per scenario,
// per-cycle expected output vectors written out by hand.
module tb_control_multiciclo;

  logic        reloj;
  logic        reset_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        PC_WR, IR_WR, REG_RD, REG_WR, SEL_I, SEL_DST, SEL_WB;
  logic [3:0]  ALU_OP;
  logic        MEM_RD, MEM_WR;
  logic [1:0]  PC_SRC;
  logic        illegal;
  logic [15:0] retired;

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_ret;
  logic [15:0] obs;

  // {PC_WR,IR_WR,REG_RD,REG_WR,MEM_RD,MEM_WR,illegal}, {SEL_I,SEL_DST,SEL_WB}, ALU_OP, PC_SRC
  assign obs = {PC_WR, IR_WR, REG_RD, REG_WR, MEM_RD, MEM_WR, illegal,
                SEL_I, SEL_DST, SEL_WB, ALU_OP, PC_SRC};

  localparam logic [15:0] V_RESET = {7'b0011000, 3'b000, 4'b0000, 2'b00};
  localparam logic [15:0] V_IDLE  = {7'b0011100, 3'b000, 4'b0000, 2'b00};
  localparam logic [15:0] V_FETCH = {7'b1111100, 3'b000, 4'b0000, 2'b00};

  control_multiciclo dut (
    .reloj     (reloj),
    .reset_n   (reset_n),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PC_WR     (PC_WR),
    .IR_WR     (IR_WR),
    .REG_RD    (REG_RD),
    .REG_WR    (REG_WR),
    .SEL_I     (SEL_I),
    .SEL_DST   (SEL_DST),
    .SEL_WB    (SEL_WB),
    .ALU_OP    (ALU_OP),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .PC_SRC    (PC_SRC),
    .illegal   (illegal),
    .retired   (retired)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b1; opcode = 6'h08; funct = 6'h00; zero = 1'b0;
    @(negedge reloj); #1;
    n_checks++;
    if (obs !== V_RESET) begin n_fail++; $display("FAIL reset_outputs got=%b want=%b", obs, V_RESET); end
    n_checks++;
    if (retired !== 16'h0000) begin n_fail++; $display("FAIL reset_retired got=%h want=0000", retired); end
    mem_ready = 1'b0;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL reset_release_fetch got=%b want=%b", obs, V_IDLE); end
    exp_ret = 16'h0000;
    @(negedge reloj);
  endtask

  // Runs one instruction from an idle FETCH; per-cycle expected vectors and mem_ready.
  // chg_c: cycle at which opcode/funct are scrambled to prove the latched copy is used.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int ncyc, input logic [15:0] exp_v [8],
                           input logic rdy_v [8], input int chg_c);
    opcode = op; funct = fn;
    for (int c = 0; c < ncyc; c++) begin
      mem_ready = rdy_v[c];
      if (c == chg_c) begin opcode = 6'h3F; funct = 6'h00; end
      #1;
      n_checks++;
      if (obs !== exp_v[c])
        $display("FAIL %s_cycle%0d got=%b want=%b", name, c + 1, obs, exp_v[c]);
      if (obs !== exp_v[c]) n_fail++;
      @(negedge reloj);
    end
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({obs, retired} !== {V_IDLE, exp_ret}) begin
      n_fail++;
      $display("FAIL %s_done got=%b/%h want=%b/%h", name, obs, retired, V_IDLE, exp_ret);
    end
    @(negedge reloj);
  endtask

  task automatic test_addi();
    logic [15:0] e [8];
    logic        r [8];
    e = '{V_FETCH, {7'b0001000, 3'b100, 4'b0010, 2'b00}, {7'b0011000, 3'b100, 4'b0010, 2'b00},
          {7'b0010000, 3'b100, 4'b0010, 2'b00}, 16'h0, 16'h0, 16'h0, 16'h0};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_ret = 16'h0001;
    run_instr("addi", 6'h08, 6'h00, 4, e, r, 2);
  endtask

  task automatic test_rtype();
    logic [15:0] e [8];
    logic        r [8];
    e = '{V_FETCH, {7'b0001000, 3'b000, 4'b0111, 2'b00}, {7'b0011000, 3'b010, 4'b0111, 2'b00},
          {7'b0010000, 3'b010, 4'b0111, 2'b00}, 16'h0, 16'h0, 16'h0, 16'h0};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_ret = 16'h0002;
    run_instr("rtype_slt", 6'h00, 6'h2A, 4, e, r, 2);
  endtask

  task automatic test_lw_wait();
    logic [15:0] e [8];
    logic        r [8];
    e = '{V_FETCH, {7'b0001000, 3'b100, 4'b0010, 2'b00}, {7'b0011000, 3'b101, 4'b0010, 2'b00},
          {7'b0011100, 3'b101, 4'b0010, 2'b00}, {7'b0011100, 3'b101, 4'b0010, 2'b00},
          {7'b0011100, 3'b101, 4'b0010, 2'b00}, {7'b0011100, 3'b101, 4'b0010, 2'b00},
          {7'b0010000, 3'b101, 4'b0010, 2'b00}};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_ret = 16'h0003;
    run_instr("lw_wait", 6'h23, 6'h00, 8, e, r, 3);
  endtask

  task automatic test_sw();
    logic [15:0] e [8];
    logic        r [8];
    e = '{V_FETCH, {7'b0001000, 3'b100, 4'b0010, 2'b00}, {7'b0011000, 3'b100, 4'b0010, 2'b00},
          {7'b0011010, 3'b100, 4'b0010, 2'b00}, 16'h0, 16'h0, 16'h0, 16'h0};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_ret = 16'h0004;
    run_instr("sw", 6'h2B, 6'h00, 4, e, r, 3);
  endtask

  task automatic test_beq();
    logic [15:0] e [8];
    logic        r [8];
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    zero = 1'b1;
    e = '{V_FETCH, {7'b0001000, 3'b100, 4'b0110, 2'b00}, {7'b1011000, 3'b100, 4'b0110, 2'b01},
          16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    exp_ret = 16'h0005;
    run_instr("beq_taken", 6'h04, 6'h00, 3, e, r, 2);
    zero = 1'b0;
    e[2] = {7'b0011000, 3'b100, 4'b0110, 2'b01};
    exp_ret = 16'h0006;
    run_instr("beq_not_taken", 6'h04, 6'h00, 3, e, r, 2);
  endtask

  task automatic test_jump();
    logic [15:0] e [8];
    logic        r [8];
    e = '{V_FETCH, {7'b1001000, 3'b000, 4'b0000, 2'b10}, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_ret = exp_ret + 16'h0001;
    run_instr("jump", 6'h02, 6'h00, 2, e, r, 9);
  endtask

  task automatic test_illegal();
    logic [15:0] e [8];
    logic        r [8];
    e = '{V_FETCH, {7'b0001001, 3'b000, 4'b0000, 2'b00}, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_instr("illegal_3f", 6'h3F, 6'h00, 2, e, r, 9);
  endtask

  task automatic test_reset_in_wb();
    logic [15:0] e [3];
    e = '{V_FETCH, {7'b0001000, 3'b000, 4'b0010, 2'b00}, {7'b0011000, 3'b010, 4'b0010, 2'b00}};
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (obs !== e[c]) begin n_fail++; $display("FAIL rst_wb_pre_cycle%0d got=%b want=%b", c + 1, obs, e[c]); end
      @(negedge reloj);
    end
    mem_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== V_RESET) begin n_fail++; $display("FAIL rst_wb_async got=%b want=%b", obs, V_RESET); end
    @(negedge reloj); #1;
    exp_ret = 16'h0000;
    n_checks++;
    if ({obs, retired} !== {V_RESET, exp_ret}) begin
      n_fail++; $display("FAIL rst_wb_held got=%b/%h want=%b/%h", obs, retired, V_RESET, exp_ret);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({obs, retired} !== {V_IDLE, exp_ret}) begin
        n_fail++; $display("FAIL rst_wb_after%0d got=%b/%h want=%b/%h", c, obs, retired, V_IDLE, exp_ret);
      end
      @(negedge reloj);
    end
  endtask

  task automatic test_wrap();
    force dut.retired_r = 16'hFFFF;
    #1;
    release dut.retired_r;
    #1;
    n_checks++;
    if (retired !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got=%h want=ffff", retired); end
    @(negedge reloj);
    exp_ret = 16'hFFFF;
    test_jump();
    n_checks++;
    if (retired !== 16'h0000) begin n_fail++; $display("FAIL wrap_result got=%h want=0000", retired); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_ret  = 16'h0000;
    test_reset();
    test_addi();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_beq();
    exp_ret = 16'h0006;
    test_jump();
    test_illegal();
    test_reset_in_wb();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
